exe_muldiv: RTL
===============

// Module: exe_muldiv
// PURPOSE
//  RV32M multiply/divide unit inside the EXE stage. It consumes operands and instructions held in the ID/EXE register.
//  Multi-cycle ops raise stall_req_o to the stall controller, which freezes IF..EXE.
//  On the release cycle it presents a one-cycle result for the EXE writeback mux.
//  It also reports its in-flight rd to the hazard logic.
// PARAMETERS
//  XLEN      32  operand/result width
//  CNT_W     6   iteration counter width (must hold XLEN)
// PORTS
//  clk_i          in   1     clock, all state updates on rising edge
//  rst_ni         in   1     reset, synchronous, active-low
//  op1_i          in   32    rs1 value from ID/EXE
//  op2_i          in   32    rs2 value from ID/EXE
//  inst_i         in   32    instruction from ID/EXE (opcode/funct3/funct7 decoded here)
//  reg_waddr_i    in   5     rd from ID/EXE
//  flush_i        in   1     jump flush: abort in-flight op, no result
//  stall_req_o    out  1     request to freeze IF/ID/EXE (combinational)
//  busy_o         out  1     state != IDLE
//  result_valid_o out  1     result_o valid this cycle (one pulse)
//  result_o       out  32    MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU result
//  reg_waddr_o    out  5     rd of the op in flight / being completed
// BEHAVIOUR
//  start = IDLE & opcode==7'b0110011 & funct7==7'b0000001 & !flush_i.
//  FSM states:
//   IDLE --start--> CALC, capturing operands, funct3 and rd.
//   CALC --done--> DONE. MUL*: done after 1 cycle. DIV/REM: done after XLEN iterations, counted by cnt.
//   DONE --> IDLE, unconditionally. The pipeline advances on this edge, so the held instruction cannot retrigger.
//   Special DIV cases go from IDLE straight to DONE:
//    divisor==0: quotient = 32'hFFFFFFFF, remainder = dividend.
//    signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
//  stall_req_o = (IDLE & start) | CALC. It is deasserted in DONE.
//  result_valid_o = 1 only in DONE. result_o and reg_waddr_o are registered and stable in DONE.
//  Latency, with start in cycle T:
//   MUL*: DONE at T+2.
//   DIV*/REM*, normal: DONE at T+XLEN+1.
//   DIV*/REM*, special case: DONE at T+1.
//  Multiply: 33x33 signed product of sign/zero-extended operands, per funct3.
//   MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
//  Divide: radix-2 restoring on absolute values, one quotient bit per cycle, MSB first.
//   Quotient sign = sign(op1) ^ sign(op2) for signed ops.
//   Remainder sign = sign(op1).
//   Sign fix is applied when entering DONE.
//  flush_i in CALC: go to IDLE next cycle, no DONE, no valid pulse. stall_req_o drops in that same cycle.
//  flush_i in DONE: result_valid_o forced 0.
//  Non-M instructions in IDLE: no effect; all outputs stay inactive.
//  Reset (rst_ni=0 at any edge, including mid-CALC):
//   state=IDLE, cnt=0, result_o=0, reg_waddr_o=0.
//   stall_req_o=0, busy_o=0, result_valid_o=0.
//  All arithmetic is unsigned XLEN+1-bit internally. No X may propagate from unused funct3 codes; these decode as MUL.
// TESTING
//  1. MUL 7 * -3 (0xFFFFFFFD) -> result_o=0xFFFFFFEB, valid at T+2, stall_req_o high for T..T+1.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14. Each valid at T+33, stall 33 cycles.
//  4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0. All valid at T+1.
//  5. Start DIVU, assert flush_i at T+10 -> IDLE at T+11, no result_valid_o, stall_req_o low from T+10.
//  6. rst_ni low at T+5 of a DIV -> all outputs 0 next edge. A new MUL issued afterward completes correctly.

Source files
------------

// File: rtl/exe_muldiv.sv
// exe_muldiv -- RV32M multiply/divide unit for the EXE stage.
//
// Decodes the M-extension instruction held in ID/EXE. Multiply takes one
// CALC cycle. Divide takes XLEN CALC cycles of radix-2 restoring division on
// absolute values, or goes straight to DONE for divide-by-zero and signed
// overflow. While the op is running it asks the stall controller to freeze
// IF..EXE. The result is presented for exactly one cycle, in DONE.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   op1_i, op2_i   rs1 / rs2 values from ID/EXE
//   inst_i         instruction from ID/EXE
//   reg_waddr_i    rd from ID/EXE
//   flush_i        jump flush: aborts an in-flight op, suppresses the result
//   stall_req_o    freeze request (combinational)
//   busy_o         unit is not idle
//   result_valid_o one-cycle result strobe
//   result_o       registered result
//   reg_waddr_o    rd of the op in flight / completing
module exe_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [31:0]     inst_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_waddr_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   acc_q;   // multiply: op1; divide: dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   dvs_q;   // multiply: op2; divide: |divisor|
  logic [XLEN-1:0]   rem_q;
  logic              neg_q_q;
  logic              neg_r_q;

  // Decode
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            start;
  logic            sgn_in;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            div_ovf;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign start  = (state == S_IDLE) && (opcode == 7'b0110011) &&
                  (funct7 == 7'b0000001) && !flush_i;

  // DIV/REM are signed (funct3[0]==0), DIVU/REMU unsigned
  assign sgn_in   = ~funct3[0];
  assign abs1     = (sgn_in && op1_i[XLEN-1]) ? (~op1_i + 1'b1) : op1_i;
  assign abs2     = (sgn_in && op2_i[XLEN-1]) ? (~op2_i + 1'b1) : op2_i;
  assign div_zero = (op2_i == '0);
  assign div_ovf  = sgn_in && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);

  // Multiply: 33x33 signed product, done as a 66-bit unsigned multiply of
  // sign-extended operands (the low 66 bits are identical).
  logic               mul_a_sgn;
  logic               mul_b_sgn;
  logic [2*XLEN+1:0]  mul_a;
  logic [2*XLEN+1:0]  mul_b;
  logic [2*XLEN+1:0]  prod;
  logic [XLEN-1:0]    mul_res;

  assign mul_a_sgn = ((f3_q == 3'b001) || (f3_q == 3'b010)) && acc_q[XLEN-1];
  assign mul_b_sgn = (f3_q == 3'b001) && dvs_q[XLEN-1];
  assign mul_a     = {{(XLEN+2){mul_a_sgn}}, acc_q};
  assign mul_b     = {{(XLEN+2){mul_b_sgn}}, dvs_q};
  assign prod      = mul_a * mul_b;
  assign mul_res   = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring-division step; the result is taken from the final step's
  // next values so DONE can be entered on the XLEN-th CALC edge.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] div_res;

  assign shifted = {rem_q, acc_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[XLEN];
  assign rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {acc_q[XLEN-2:0], ge};
  assign div_res = f3_q[1] ? (neg_r_q ? (~rem_nxt + 1'b1) : rem_nxt)
                           : (neg_q_q ? (~quo_nxt + 1'b1) : quo_nxt);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= '0;
      f3_q        <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q        <= funct3;
            reg_waddr_o <= reg_waddr_i;
            cnt         <= '0;
            rem_q       <= '0;
            if (funct3[2]) begin
              acc_q   <= abs1;
              dvs_q   <= abs2;
              neg_q_q <= sgn_in && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
              neg_r_q <= sgn_in && op1_i[XLEN-1];
              if (div_zero || div_ovf) begin
                if (funct3[1])
                  result_o <= div_zero ? op1_i : '0;
                else
                  result_o <= div_zero ? '1 : op1_i;
                state <= S_DONE;
              end else begin
                state <= S_CALC;
              end
            end else begin
              acc_q <= op1_i;
              dvs_q <= op2_i;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else if (!f3_q[2]) begin
            result_o <= mul_res;
            state    <= S_DONE;
          end else begin
            acc_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) begin
              result_o <= div_res;
              state    <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_req_o    = start || ((state == S_CALC) && !flush_i);
  assign busy_o         = (state != S_IDLE);
  assign result_valid_o = (state == S_DONE) && !flush_i;

endmodule
